// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, sizes and round-robin search for the arb_rr4 arbiter
package arb_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // First requester at or after ptr, wrapping; returns ptr when nobody requests.
    function automatic logic [IDX_W-1:0] next_rr(
        input logic [NREQ-1:0]  req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] pos;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            pos = ptr + IDX_W'(k);
            if (!found && req[pos]) begin
                win   = pos;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/arb_rr4_if.sv
// rtl/arb_rr4_if.sv - request/grant bundle between requesters and the arbiter
interface arb_rr4_if;
    import arb_pkg::*;

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;

    modport master (output req, input gnt, input gnt_idx, input gnt_vld);
    modport slave  (input req, output gnt, output gnt_idx, output gnt_vld);

endinterface

// File: rtl/dec2to4_onehot.sv
// rtl/dec2to4_onehot.sv - 2-to-4 one-hot decoder with enable
module dec2to4_onehot
    import arb_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [NREQ-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/arb_rr4.sv
// rtl/arb_rr4.sv - four-requester round-robin arbiter with a bounded hold time
module arb_rr4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic     clk,
    input  logic     rst,
    arb_rr4_if.slave bus
);

    localparam logic [7:0] CNT_MAX = 8'(MAX_HOLD - 1);

    state_t           state;
    state_t           state_n;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_n;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_n;
    logic [IDX_W-1:0] win;
    logic [7:0]       cnt;
    logic [7:0]       cnt_n;
    logic [NREQ-1:0]  others;
    logic             regrant;

    always_comb begin
        win     = next_rr(bus.req, ptr);
        others  = bus.req & ~(NREQ'(1) << idx);
        regrant = 1'b0;
        state_n = state;
        idx_n   = idx;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            IDLE: regrant = |bus.req;
            BUSY: begin
                if (!bus.req[idx]) begin
                    if (|others) begin
                        regrant = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (cnt == CNT_MAX) begin
                    // Saturated: a sole requester keeps the grant until a competitor shows up.
                    regrant = |others;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        // In BUSY ptr is idx+1, so the current grantee is searched last and cannot re-win.
        if (regrant) begin
            state_n = BUSY;
            idx_n   = win;
            ptr_n   = win + IDX_W'(1);
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    assign bus.gnt_vld = (state == BUSY);
    assign bus.gnt_idx = idx;

    dec2to4_onehot u_dec (
        .en     (state == BUSY),
        .idx    (idx),
        .onehot (bus.gnt)
    );

endmodule

// File: tb/tb_arb_rr4.sv
// tb/tb_arb_rr4.sv - self-checking bench for arb_rr4 (MAX_HOLD=8 and MAX_HOLD=2 instances)
module tb_arb_rr4;

    logic       clk;
    logic       rst;
    logic [3:0] req;

    int n_checks = 0;
    int n_errors = 0;

    arb_rr4_if bus8 ();
    arb_rr4_if bus2 ();
    assign bus8.req = req;
    assign bus2.req = req;

    arb_rr4 #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    arb_rr4 #(.MAX_HOLD(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner (-1 = none), cycles held so far, last owner for rotation.
    int owner [2];
    int held  [2];
    int last  [2];
    int sidx  [2];
    int lim   [2] = '{8, 2};

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1;
            held[k]  = 0;
            last[k]  = 3;
            sidx[k]  = 0;
        end
    endtask

    function automatic int pick(input int k, input logic [3:0] r);
        int j;
        for (int s = 1; s <= 4; s++) begin
            j = (last[k] + s) % 4;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_grant(input int k, input int w);
        owner[k] = w;
        last[k]  = w;
        sidx[k]  = w;
        held[k]  = 1;
    endtask

    task automatic model_edge(input int k, input logic [3:0] r);
        int w;
        if (owner[k] < 0 || !r[owner[k]]) begin
            w = pick(k, r);
            if (w >= 0) model_grant(k, w);
            else owner[k] = -1;
        end else if (held[k] >= lim[k] && (r & ~4'(1 << owner[k])) != 4'b0) begin
            model_grant(k, pick(k, r));
        end else begin
            held[k]++;
        end
    endtask

    task automatic cmp_model(input int k, input logic [3:0] g, input logic [1:0] ix, input logic v);
        logic [3:0] eg;
        eg = (owner[k] >= 0) ? 4'(1 << owner[k]) : 4'b0;
        check($sformatf("model_gnt_i%0d", k), 32'(g), 32'(eg));
        check($sformatf("model_vld_i%0d", k), 32'(v), (owner[k] >= 0) ? 1 : 0);
        check($sformatf("model_idx_i%0d", k), 32'(ix), sidx[k]);
    endtask

    task automatic step();
        logic [3:0] r;
        r = req;
        model_edge(0, r);
        model_edge(1, r);
        @(posedge clk);
        #1;
        cmp_model(0, bus8.gnt, bus8.gnt_idx, bus8.gnt_vld);
        cmp_model(1, bus2.gnt, bus2.gnt_idx, bus2.gnt_vld);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t       vecs [10];
    int         rot  [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int         run;
    int         wt [4];
    logic [3:0] r_edge;
    logic [3:0] g_prev;

    initial begin
        vecs[0] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
        vecs[1] = '{4'b1011, 4'b1000, 2'd3, 1'b1};
        vecs[2] = '{4'b0011, 4'b0001, 2'd0, 1'b1};
        vecs[3] = '{4'b0011, 4'b0001, 2'd0, 1'b1};
        vecs[4] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
        vecs[5] = '{4'b0000, 4'b0000, 2'd1, 1'b0};
        vecs[6] = '{4'b0000, 4'b0000, 2'd1, 1'b0};
        vecs[7] = '{4'b0101, 4'b0100, 2'd2, 1'b1};
        vecs[8] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        vecs[9] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

        // Reset with all requests high, then rotation on the MAX_HOLD=2 instance
        rst = 1'b1;
        req = 4'b1111;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_gnt8", 32'(bus8.gnt), 0);
        check("reset_gnt2", 32'(bus2.gnt), 0);
        check("reset_vld8", 32'(bus8.gnt_vld), 0);
        check("reset_idx8", 32'(bus8.gnt_idx), 0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 0) check("release_gnt2", 32'(bus2.gnt), 32'h1);
            check($sformatf("rotate_idx2_%0d", i), 32'(bus2.gnt_idx), rot[i]);
        end

        // Table-driven sequence incl. wrap handoff 3->0
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req = vecs[i].req;
            step();
            check($sformatf("vec%0d_gnt", i), 32'(bus8.gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_idx", i), 32'(bus8.gnt_idx), 32'(vecs[i].idx));
            check($sformatf("vec%0d_vld", i), 32'(bus8.gnt_vld), 32'(vecs[i].vld));
        end

        // Sole requester holds indefinitely, then releases to idle
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("sole_gnt_%0d", i), 32'(bus8.gnt), 32'h4);
        end
        req = 4'b0000;
        step();
        check("sole_release_gnt", 32'(bus8.gnt), 0);
        check("sole_release_vld", 32'(bus8.gnt_vld), 0);

        // Forced preemption after exactly MAX_HOLD cycles
        do_reset();
        req = 4'b0001;
        step();
        run = (bus8.gnt == 4'b0001) ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 1) req = 4'b0101;
            step();
            if (bus8.gnt == 4'b0001) run++;
            else break;
        end
        check("preempt_hold_cycles", run, 8);
        check("preempt_next_gnt", 32'(bus8.gnt), 32'h4);

        // Asynchronous reset mid-grant, then search restarts from 0
        do_reset();
        req = 4'b0010;
        step();
        check("midrst_pre_gnt", 32'(bus8.gnt), 32'h2);
        req = 4'b0110;
        step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_gnt8", 32'(bus8.gnt), 0);
        check("midrst_vld8", 32'(bus8.gnt_vld), 0);
        check("midrst_gnt2", 32'(bus2.gnt), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("midrst_ptr0_gnt", 32'(bus8.gnt), 32'h2);

        // Random traffic against the model plus protocol checks
        do_reset();
        for (int i = 0; i < 4; i++) wt[i] = 0;
        g_prev = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            r_edge = req;
            step();
            check("rand_onehot0", $countones(bus8.gnt) <= 1 ? 1 : 0, 1);
            if (bus8.gnt != 4'b0000 && bus8.gnt != g_prev)
                check("rand_grant_active", ((bus8.gnt & r_edge) != 4'b0000) ? 1 : 0, 1);
            for (int i = 0; i < 4; i++) begin
                if (r_edge[i] && !bus8.gnt[i]) wt[i]++;
                else wt[i] = 0;
                check($sformatf("rand_wait_%0d", i), (wt[i] <= 3 * 8 + 3) ? 1 : 0, 1);
            end
            g_prev = bus8.gnt;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
